ex_muldiv_sequencer: RTL and testbench
======================================

Name: ex_muldiv_sequencer

Overview:
- Multi-cycle sequencer for RV32M operations issued from the execution stage.
- Accepts forwarded operands and funct3 when the EX-stage instruction is M-extension.
- Single-cycle registered path for MUL*; iterative 32-step restoring divider for DIV*/REM*.
- Drives a stall to hold IF/ID/EX while busy; returns one registered result the EX stage selects in place of the ALU result.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  EX instruction is M-extension and valid (level, held while stalled)
- flush  in  1  synchronous kill from branch/jump redirect
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand_a  in  XLEN  rs1 value after forwarding
- operand_b  in  XLEN  rs2 value after forwarding
- rd_in  in  5  destination register of issuing instruction
- stall  out  1  hold pipeline registers upstream of EX/MEM
- result_valid  out  1  result available this cycle (one-cycle pulse)
- result  out  XLEN  final MUL/DIV/REM value
- rd_out  out  5  rd captured at acceptance
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, stall=0, result_valid=0, result=0, rd_out=0, busy=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE: on start && !flush, latch funct3, operands, rd_in.
  - MUL* or divide special case -> DONE, result registered at that edge.
  - Otherwise -> CALC, counter=31.
- CALC: one restoring step per cycle on unsigned magnitudes (remainder 33 bits). At counter==0 apply sign fixup, register result, -> DONE; else counter-1.
- DONE: result_valid=1, stall=0 so the instruction retires to EX/MEM; -> IDLE unconditionally. start is ignored in DONE (same instruction still present).
- stall = (IDLE && start && !flush) || CALC. Combinational, so the issuing cycle itself stalls.
- Latency, start first seen in cycle 0:
  - MUL* and special cases: result_valid in cycle 1.
  - Regular divide: CALC cycles 1-32, result_valid in cycle 33.
- MUL: low 32 bits of product. MULH: signed×signed high. MULHSU: signed×unsigned high. MULHU: unsigned high. Computed as a 33×33 signed product.
- Division follows the RISC-V spec:
  - Signs: quotient negative iff operand signs differ; remainder takes dividend sign.
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = dividend.
  - Signed overflow (0x80000000 / -1): DIV = 0x80000000; REM = 0.
- flush in any state -> IDLE next edge; no result_valid; stall deasserts same cycle; latched state discarded.
- flush and DONE in the same cycle: flush wins, result_valid forced 0.
- reset asserted mid-CALC: immediate return to reset values; no partial result.
- result and rd_out hold their last value outside DONE.

Optional Feature:
- DIV_EARLY_OUT_EN defined: in IDLE, an unsigned/magnitude divisor greater than the dividend magnitude goes straight to DONE with quotient 0 and remainder = dividend, in 1-cycle latency like the special cases.
- Undefined: such operations take the full 32 CALC cycles with identical results.

Decomposition:
- Package muldiv_pkg: funct3 encoding constants, state enum (IDLE/CALC/DONE), XLEN constant, special-case result constants (all ones, 0x80000000).
- Sub-module restoring_div_step: combinational single shift-subtract step (remainder, quotient, divisor in; next remainder/quotient out), instantiated once inside the CALC path.

Test Plan:
- MUL 7×-3 -> result_valid cycle 1, result 0xFFFFFFEB; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1×2 -> 0xFFFFFFFF.
- DIV -20/3 -> stall high cycles 0-32, result_valid cycle 33, result 0xFFFFFFFA. REM -20/3 -> 0xFFFFFFFE. DIVU 100/7 -> 14.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM same operands -> 0. All valid in cycle 1.
- Start DIV, assert flush in cycle 10 -> stall 0 that cycle, no result_valid, next start accepted in cycle 11.
- Hold start high through DONE -> exactly one result_valid pulse per instruction; rd_out equals rd_in captured at acceptance.
- Drop reset in cycle 5 of CALC -> all outputs 0 immediately. With DIV_EARLY_OUT_EN, DIVU 3/10 -> quotient 0 in cycle 1; without it, cycle 33.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer signal bundle; master is the EX stage.
interface ex_muldiv_sequencer_if;

    logic                         start;
    logic                         flush;
    logic [2:0]                   funct3;
    logic [muldiv_pkg::XLEN-1:0]  operand_a;
    logic [muldiv_pkg::XLEN-1:0]  operand_b;
    logic [4:0]                   rd_in;
    logic                         stall;
    logic                         result_valid;
    logic [muldiv_pkg::XLEN-1:0]  result;
    logic [4:0]                   rd_out;
    logic                         busy;

    modport master (
        output start, flush, funct3, operand_a, operand_b, rd_in,
        input  stall, result_valid, result, rd_out, busy
    );

    modport slave (
        input  start, flush, funct3, operand_a, operand_b, rd_in,
        output stall, result_valid, result, rd_out, busy
    );

endinterface

// File: rtl/restoring_div_step.sv
// One shift-subtract step of an unsigned restoring divider.
module restoring_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] div_in,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {2'b00, div_in};

    // Borrow out of the subtraction means the trial failed: keep the shifted remainder.
    always_comb begin
        rem_out = diff[XLEN:0];
        quo_out = {quo_in[XLEN-2:0], 1'b1};
        if (diff[XLEN+1]) begin
            rem_out = shifted[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// RV32M sequencer: 1-cycle MUL*, 32-step restoring DIV*/REM*, pipeline stall control.
// Optional DIV_EARLY_OUT_EN: divisor magnitude > dividend magnitude finishes in one cycle.
module ex_muldiv_sequencer
    import muldiv_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    ex_muldiv_sequencer_if.slave bus
);

    state_t          state_q, state_d;
    logic [4:0]      count_q;
    logic [4:0]      rd_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q, dvs_q;
    logic            rem_sel_q, neg_quo_q, neg_rem_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_out_q;

    logic            accept, stall_c, valid_c;

    logic [2:0]      f3;
    logic [XLEN-1:0] a, b;
    logic            is_div, div_signed, is_rem;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, early, quick;
    logic [XLEN-1:0] quick_res;

    logic            mul_a_sx, mul_b_sx;
    logic [2*XLEN-1:0] mul_a, mul_b, product;
    logic [XLEN-1:0] mul_res;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] quo_fix, rem_fix, calc_res;

    assign f3         = bus.funct3;
    assign a          = bus.operand_a;
    assign b          = bus.operand_b;
    assign is_div     = f3[2];
    assign div_signed = ~f3[0];
    assign is_rem     = f3[1];

    assign a_neg = div_signed & a[XLEN-1];
    assign b_neg = div_signed & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign div_zero = (b == '0);
    assign div_ovf  = div_signed && (a == SIGN_MIN) && (b == ALL_ONES);

`ifdef DIV_EARLY_OUT_EN
    assign early = (b_mag > a_mag);
`else
    assign early = 1'b0;
`endif

    assign quick = ~is_div | div_zero | div_ovf | early;

    // 33x33 signed product, sign-extended to 64 bits so the low 64 bits are exact.
    assign mul_a_sx = ((f3 == F3_MULH) || (f3 == F3_MULHSU)) & a[XLEN-1];
    assign mul_b_sx = (f3 == F3_MULH) & b[XLEN-1];
    assign mul_a    = {{XLEN{mul_a_sx}}, a};
    assign mul_b    = {{XLEN{mul_b_sx}}, b};
    assign product  = mul_a * mul_b;
    assign mul_res  = (f3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    always_comb begin
        quick_res = '0;
        if (!is_div)
            quick_res = mul_res;
        else if (div_zero)
            quick_res = is_rem ? a : ALL_ONES;
        else if (div_ovf)
            quick_res = is_rem ? '0 : SIGN_MIN;
        else
            quick_res = is_rem ? a : '0;
    end

    restoring_div_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .div_in  (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign quo_fix  = neg_quo_q ? -step_quo : step_quo;
    assign rem_fix  = neg_rem_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
    assign calc_res = rem_sel_q ? rem_fix : quo_fix;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        stall_c = 1'b0;
        valid_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    accept  = 1'b1;
                    stall_c = 1'b1;
                    state_d = quick ? DONE : CALC;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (count_q == '0)
                        state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_c = ~bus.flush;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            rd_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else if (accept) begin
            count_q   <= 5'd31;
            rd_q      <= bus.rd_in;
            rem_q     <= '0;
            quo_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_sel_q <= is_rem;
            neg_quo_q <= div_signed & (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_q <= a_neg;
            if (quick) begin
                result_q <= quick_res;
                rd_out_q <= bus.rd_in;
            end
        end else if ((state_q == CALC) && !bus.flush) begin
            rem_q   <= step_rem;
            quo_q   <= step_quo;
            count_q <= count_q - 5'd1;
            if (count_q == '0) begin
                result_q <= calc_res;
                rd_out_q <= rd_q;
            end
        end
    end

    // Gating with reset keeps stall low while reset is held, even with start asserted.
    assign bus.stall        = stall_c & reset;
    assign bus.result_valid = valid_c;
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
    assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Directed + random scoreboard bench for ex_muldiv_sequencer.
module tb_ex_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_muldiv_sequencer_if bus ();

    ex_muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   expected_pulses = 0;

    always @(negedge clk)
        if (bus.result_valid === 1'b1)
            pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f3)
            F3_MUL:    begin p = sa * sb; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!f3[0] && a[31]) ? (32'h0 - a) : a;
        mb = (!f3[0] && b[31]) ? (32'h0 - b) : b;
        if (!f3[2]) return 1;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`else
        if (mb > ma) return 33;
`endif
        return 33;
    endfunction

    task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int lat,
                         input logic [31:0] exp_res);
        exp_t e;
        int   n;
        bit   got;
        bit   stall_ok;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.flush     = 1'b0;
        bus.funct3    = f3;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in     = rd;
        sb.push_back('{res: exp_res, rd: rd});
        expected_pulses++;
        n = 0;
        got = 1'b0;
        stall_ok = 1'b1;
        while (!got && n <= 40) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                got = 1'b1;
                if (bus.stall !== 1'b0) stall_ok = 1'b0;
            end else begin
                if (bus.stall !== 1'b1) stall_ok = 1'b0;
                @(posedge clk); #1;
                n++;
                // Later-cycle operand changes must not disturb the accepted instruction.
                bus.operand_a = $urandom;
                bus.operand_b = $urandom;
                bus.rd_in     = 5'($urandom);
            end
        end
        check({tag, "_valid_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_latency"}, 64'(n), 64'(lat));
            check({tag, "_stall_window"}, 64'(stall_ok), 64'd1);
            e = sb.pop_front();
            check({tag, "_result"}, 64'(bus.result), 64'(e.res));
            check({tag, "_rd_out"}, 64'(bus.rd_out), 64'(e.rd));
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check({tag, "_single_pulse"}, 64'(bus.result_valid), 64'd0);
        check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        if (got)
            check({tag, "_result_hold"}, 64'(bus.result), 64'(exp_res));
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.funct3    = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rd_in     = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_valid", 64'(bus.result_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_rd_out", 64'(bus.rd_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b1;

        issue("mul",      F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  1,  32'hFFFF_FFEB);
        issue("mulhu",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  1,  32'hFFFF_FFFE);
        issue("mulhsu",   F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd3,  1,  32'hFFFF_FFFF);
        issue("mulh",     F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd4,  1,  32'h4000_0000);
        issue("div_neg",  F3_DIV,    32'hFFFF_FFEC,  32'd3,         5'd5,  33, 32'hFFFF_FFFA);
        issue("rem_neg",  F3_REM,    32'hFFFF_FFEC,  32'd3,         5'd6,  33, 32'hFFFF_FFFE);
        issue("divu",     F3_DIVU,   32'd100,        32'd7,         5'd7,  33, 32'd14);
        issue("divu_max", F3_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd8,  33, 32'hFFFF_FFFF);
        issue("divu_z",   F3_DIVU,   32'd5,          32'd0,         5'd9,  1,  32'hFFFF_FFFF);
        issue("rem_z",    F3_REM,    32'd5,          32'd0,         5'd10, 1,  32'd5);
        issue("div_ovf",  F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1,  32'h8000_0000);
        issue("rem_ovf",  F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 1,  32'h0);
        issue("div_nd",   F3_DIV,    32'd20,         32'hFFFF_FFFD, 5'd13, 33, 32'hFFFF_FFFA);
        issue("rem_nd",   F3_REM,    32'd20,         32'hFFFF_FFFD, 5'd14, 33, 32'd2);

        // Flush in cycle 10 of a divide; next instruction issues in cycle 11.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_DIV;
        bus.operand_a = 32'd1000; bus.operand_b = 32'd7; bus.rd_in = 5'd30;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_stall", 64'(bus.stall), 64'd0);
        check("flush_valid", 64'(bus.result_valid), 64'd0);
        issue("after_flush", F3_MUL, 32'd6, 32'd9, 5'd15, 1, 32'd54);

        // Flush landing on DONE suppresses the pulse.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_MUL;
        bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.rd_in = 5'd16;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        check("done_flush_valid", 64'(bus.result_valid), 64'd0);
        check("done_flush_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("done_flush_idle", 64'(bus.busy), 64'd0);

        issue("pre_reset", F3_REMU, 32'd23, 32'd5, 5'd17, 33, 32'd3);

        // Asynchronous reset in cycle 5 of CALC.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.funct3 = F3_DIV;
        bus.operand_a = 32'd1000; bus.operand_b = 32'd3; bus.rd_in = 5'd18;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_stall", 64'(bus.stall), 64'd0);
        check("midrst_valid", 64'(bus.result_valid), 64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        check("midrst_rd_out", 64'(bus.rd_out), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

`ifdef DIV_EARLY_OUT_EN
        issue("early_divu", F3_DIVU, 32'd3, 32'd10, 5'd19, 1, 32'd0);
        issue("early_remu", F3_REMU, 32'd3, 32'd10, 5'd20, 1, 32'd3);
        issue("early_rem",  F3_REM,  32'hFFFF_FFFD, 32'd10, 5'd21, 1, 32'hFFFF_FFFD);
`else
        issue("early_divu", F3_DIVU, 32'd3, 32'd10, 5'd19, 33, 32'd0);
        issue("early_remu", F3_REMU, 32'd3, 32'd10, 5'd20, 33, 32'd3);
        issue("early_rem",  F3_REM,  32'hFFFF_FFFD, 32'd10, 5'd21, 33, 32'hFFFF_FFFD);
`endif

        for (int i = 0; i < 10; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rb  = rb >> $urandom_range(0, 31);
            issue("rand", rf3, ra, rb, 5'(i + 22), exp_lat(rf3, ra, rb), model(rf3, ra, rb));
        end

        @(posedge clk); #1;
        check("pulse_count", 64'(pulses), 64'(expected_pulses));
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
